// File: rtl/zjh_nibble_adder_seq.sv
// Nibble-serial WIDTH-bit add/subtract sequencer around one shared 4-bit ripple adder slice.
// Optional signed-overflow output enabled by defining ZJH_SEQ_OVF_EN.
`timescale 1ns/1ps

module zjh_nibble_adder_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             clr,
    input  logic             sub,
    input  logic             cin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] sum,
`ifdef ZJH_SEQ_OVF_EN
    output logic             ovf,
`endif
    output logic             cout
);

    localparam int NUM_NIB = WIDTH / 4;
    localparam int NIB_W   = (NUM_NIB > 1) ? $clog2(NUM_NIB) : 1;
    localparam logic [NIB_W-1:0] LAST_IDX = NIB_W'(NUM_NIB - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // 74HC283-style 4-bit ripple slice: returns {cout, s[3:0]}.
    function automatic logic [4:0] nib_add(input logic [3:0] x, input logic [3:0] y, input logic c);
        logic [3:0] s;
        logic       k;
        s = 4'b0000;
        k = c;
        for (int i = 0; i < 4; i++) begin
            s[i] = x[i] ^ y[i] ^ k;
            k    = (x[i] & y[i]) | (k & (x[i] ^ y[i]));
        end
        return {k, s};
    endfunction

`ifdef ZJH_SEQ_OVF_EN
    // Carry into bit 3 of the slice, needed for the signed-overflow XOR.
    function automatic logic nib_c3(input logic [3:0] x, input logic [3:0] y, input logic c);
        logic k;
        k = c;
        for (int i = 0; i < 3; i++) begin
            k = (x[i] & y[i]) | (k & (x[i] ^ y[i]));
        end
        return k;
    endfunction
`endif

    state_t             state_r;
    state_t             state_next_s;
    logic [NIB_W-1:0]   idx_r;
    logic               carry_r;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic [WIDTH-1:0]   sum_r;
    logic               cout_r;
    logic               ready_r;
    logic               done_r;
    logic               accept_s;
    logic               last_s;
    logic [3:0]         a_nib_s;
    logic [3:0]         b_nib_s;
    logic [4:0]         add_s;
`ifdef ZJH_SEQ_OVF_EN
    logic               ovf_r;
`endif

    // Next-state logic; clr overrides everything, including a same-cycle start.
    always_comb begin
        state_next_s = state_r;
        accept_s     = 1'b0;
        last_s       = (idx_r == LAST_IDX);
        if (clr) begin
            state_next_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_next_s = ST_RUN;
                        accept_s     = 1'b1;
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (last_s) begin
                        state_next_s = ST_DONE;
                    end else begin
                        state_next_s = ST_RUN;
                    end
                end
                ST_DONE: state_next_s = ST_IDLE;
                default: state_next_s = ST_IDLE;
            endcase
        end
    end

    // Select the current nibble pair and run it through the shared slice.
    always_comb begin
        a_nib_s = a_r[{idx_r, 2'b00} +: 4];
        b_nib_s = b_r[{idx_r, 2'b00} +: 4];
        add_s   = nib_add(a_nib_s, b_nib_s, carry_r);
    end

    // State register; ready/done are registered from the next state so they track it exactly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            ready_r <= 1'b1;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            ready_r <= (state_next_s == ST_IDLE);
            done_r  <= (state_next_s == ST_DONE);
        end
    end

    // Operand latch, carry feedback, nibble counter and result assembly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_r   <= '0;
            carry_r <= 1'b0;
            a_r     <= '0;
            b_r     <= '0;
            sum_r   <= '0;
            cout_r  <= 1'b0;
        end else if (clr) begin
            idx_r <= '0;
        end else if (accept_s) begin
            a_r     <= a;
            b_r     <= sub ? ~b : b;
            carry_r <= sub ? 1'b1 : cin;
            idx_r   <= '0;
            sum_r   <= '0;
        end else if (state_r == ST_RUN) begin
            sum_r[{idx_r, 2'b00} +: 4] <= add_s[3:0];
            carry_r                    <= add_s[4];
            if (last_s) begin
                idx_r  <= '0;
                cout_r <= add_s[4];
            end else begin
                idx_r <= idx_r + NIB_W'(1);
            end
        end
    end

`ifdef ZJH_SEQ_OVF_EN
    // Signed overflow of the top nibble, held with the sum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_r <= 1'b0;
        end else if (clr) begin
            ovf_r <= ovf_r;
        end else if (accept_s) begin
            ovf_r <= 1'b0;
        end else if ((state_r == ST_RUN) && last_s) begin
            ovf_r <= nib_c3(a_nib_s, b_nib_s, carry_r) ^ add_s[4];
        end
    end

    assign ovf = ovf_r;
`endif

    assign ready = ready_r;
    assign done  = done_r;
    assign sum   = sum_r;
    assign cout  = cout_r;

endmodule

// File: tb/tb_zjh_nibble_adder_seq.sv
// Table-driven self-checking bench for zjh_nibble_adder_seq (WIDTH=16), plus handshake corner sequences.
`timescale 1ns/1ps

module tb_zjh_nibble_adder_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        clr;
    logic        sub;
    logic        cin;
    logic [15:0] a;
    logic [15:0] b;
    logic        ready;
    logic        done;
    logic [15:0] sum;
    logic        cout;
`ifdef ZJH_SEQ_OVF_EN
    logic        ovf;
`endif

    int checks = 0;
    int passes = 0;

    typedef struct {
        logic [15:0] va;
        logic [15:0] vb;
        logic        vsub;
        logic        vcin;
        logic [15:0] esum;
        logic        ecout;
        logic        eovf;
    } vec_t;

    vec_t vecs[12];

    zjh_nibble_adder_seq #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .clr   (clr),
        .sub   (sub),
        .cin   (cin),
        .a     (a),
        .b     (b),
        .ready (ready),
        .done  (done),
        .sum   (sum),
`ifdef ZJH_SEQ_OVF_EN
        .ovf   (ovf),
`endif
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Samples at negedges until done; counts samples since the accept edge.
    task automatic wait_done(input int n0, output int n, output logic rdy_low, output logic seen);
        n       = n0;
        rdy_low = 1'b1;
        seen    = 1'b0;
        while (n < 20 && !seen) begin
            @(negedge clk);
            n++;
            if (ready !== 1'b0) rdy_low = 1'b0;
            if (done === 1'b1) seen = 1'b1;
        end
        chk("done_seen", {31'd0, seen}, 32'd1);
    endtask

    task automatic accept(input logic [15:0] va, input logic [15:0] vb, input logic vsub, input logic vcin);
        @(negedge clk);
        a     = va;
        b     = vb;
        sub   = vsub;
        cin   = vcin;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic run_vec(input int i);
        int   n;
        logic rl;
        logic sn;
        accept(vecs[i].va, vecs[i].vb, vecs[i].vsub, vecs[i].vcin);
        wait_done(0, n, rl, sn);
        chk($sformatf("latency[%0d]", i), n, 32'd5);
        chk($sformatf("ready_low[%0d]", i), {31'd0, rl}, 32'd1);
        chk($sformatf("sum[%0d]", i), {16'd0, sum}, {16'd0, vecs[i].esum});
        chk($sformatf("cout[%0d]", i), {31'd0, cout}, {31'd0, vecs[i].ecout});
`ifdef ZJH_SEQ_OVF_EN
        chk($sformatf("ovf[%0d]", i), {31'd0, ovf}, {31'd0, vecs[i].eovf});
`endif
        @(negedge clk);
        chk($sformatf("done_pulse[%0d]", i), {31'd0, done}, 32'd0);
        chk($sformatf("ready_after[%0d]", i), {31'd0, ready}, 32'd1);
        chk($sformatf("sum_held[%0d]", i), {16'd0, sum}, {16'd0, vecs[i].esum});
    endtask

    initial begin
        int   n;
        logic rl;
        logic sn;
        logic got_done;

        vecs[0]  = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
        vecs[1]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2]  = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0001, 1'b0, 1'b0};
        vecs[3]  = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[4]  = '{16'h0007, 16'h0005, 1'b1, 1'b0, 16'h0002, 1'b1, 1'b0};
        vecs[5]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[6]  = '{16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        vecs[7]  = '{16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0};
        vecs[8]  = '{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[9]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[10] = '{16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1};
        vecs[11] = '{16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0};

        rst_n = 1'b0;
        start = 1'b0;
        clr   = 1'b0;
        sub   = 1'b0;
        cin   = 1'b0;
        a     = 16'h0000;
        b     = 16'h0000;
        repeat (2) @(negedge clk);
        chk("rst_ready", {31'd0, ready}, 32'd1);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_sum", {16'd0, sum}, 32'd0);
        chk("rst_cout", {31'd0, cout}, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) run_vec(i);

        // start re-asserted two cycles into RUN must be ignored, then accepted after done
        accept(16'h1234, 16'h4321, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        a     = 16'hFFFF;
        b     = 16'hFFFF;
        start = 1'b1;
        wait_done(2, n, rl, sn);
        chk("busy_latency", n, 32'd5);
        chk("busy_sum", {16'd0, sum}, 32'h5555);
        chk("busy_cout", {31'd0, cout}, 32'd0);
        @(negedge clk);
        chk("busy_idle_ready", {31'd0, ready}, 32'd1);
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(0, n, rl, sn);
        chk("second_latency", n, 32'd5);
        chk("second_sum", {16'd0, sum}, 32'hFFFE);
        chk("second_cout", {31'd0, cout}, 32'd1);

        // clr together with start in IDLE: clr wins
        @(negedge clk);
        @(negedge clk);
        a     = 16'h0101;
        b     = 16'h0101;
        start = 1'b1;
        clr   = 1'b1;
        @(negedge clk);
        chk("clrstart_ready", {31'd0, ready}, 32'd1);
        chk("clrstart_sum", {16'd0, sum}, 32'hFFFE);
        start = 1'b0;
        clr   = 1'b0;

        // clr in the third RUN cycle aborts; partial sum and prior cout stay
        accept(16'h1234, 16'h4321, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("clr_ready", {31'd0, ready}, 32'd1);
        chk("clr_done", {31'd0, done}, 32'd0);
        chk("clr_sum_kept", {16'd0, sum}, 32'h0055);
        chk("clr_cout_kept", {31'd0, cout}, 32'd1);
        got_done = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (done === 1'b1) got_done = 1'b1;
        end
        chk("clr_no_done", {31'd0, got_done}, 32'd0);

        // async reset mid-RUN
        accept(16'h1111, 16'h1111, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        chk("prerst_sum", {16'd0, sum}, 32'h0002);
        rst_n = 1'b0;
        #1;
        chk("midrst_ready", {31'd0, ready}, 32'd1);
        chk("midrst_done", {31'd0, done}, 32'd0);
        chk("midrst_sum", {16'd0, sum}, 32'd0);
        chk("midrst_cout", {31'd0, cout}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_vec(0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/zjh_nibble_adder_seq.md
Name: zjh_nibble_adder_seq

Overview:
- Sequencer that time-shares one 4-bit ripple adder slice (74HC283-equivalent: A+B+Cin -> S, Cout) to add or subtract WIDTH-bit operands, one nibble per clock, LSB nibble first.
- Owns operand latching, carry feedback register, nibble index counter, result assembly and a start/done handshake.
- Sits between a host register file or FSM and the shared 4-bit adder datapath.

Parameters:
- WIDTH, 16, operand/result width in bits; multiple of 4, minimum 4.
- NIB_W, $clog2(WIDTH/4) (minimum 1), width of the nibble index counter; derived, not overridden.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; accepted only when ready=1.
- clr  input  1  synchronous abort; returns to IDLE.
- sub  input  1  0 = a+b+cin; 1 = a-b (cin ignored).
- cin  input  1  carry-in for add.
- a  input  WIDTH  operand A, sampled on accept.
- b  input  WIDTH  operand B, sampled on accept.
- ready  output  1  high in IDLE only.
- done  output  1  one-cycle pulse when sum/cout are valid.
- sum  output  WIDTH  result; held until next accept.
- cout  output  1  final carry; for sub, 1 = no borrow.

Behaviour:
- Clock/reset: one clock, clk; reset asynchronous active-low, rst_n.
- Reset values: state=IDLE, ready=1, done=0, sum=0, cout=0, index=0, carry=0, operand registers=0.
- States: IDLE, RUN, DONE.
- IDLE -> RUN on start & ~clr:
  - latch a.
  - latch b, or ~b when sub=1.
  - carry <= sub ? 1 : cin.
  - index <= 0.
  - sum cleared to 0.
- RUN, each cycle:
  - adder inputs: A nibble[index], B' nibble[index], carry.
  - S written to sum[4*index+3 : 4*index].
  - carry <= adder Cout.
  - index increments.
- RUN -> DONE after the cycle with index = WIDTH/4-1; cout <= Cout of that last nibble.
- DONE: done=1 for exactly one cycle; unconditional -> IDLE next cycle; ready=0 during DONE.
- Latency: start accepted at edge T; done high in cycle T+WIDTH/4+1 (WIDTH=16: 5 cycles after the accept edge). Next start is accepted earliest one cycle after done.
- sum/cout: stable from done until the next accepted start. Intermediate nibbles are visible on sum during RUN; host must not sample until done.
- start while ready=0: ignored, no queuing; operand registers unchanged.
- clr, any state: next state IDLE, done=0, index=0; sum/cout keep their current values.
- clr and start together: clr wins, no accept.
- Async reset mid-operation: immediate return to reset values; the operation is lost.
- Arithmetic is modulo 2^WIDTH; no saturation.

Optional Feature:
- Macro: ZJH_SEQ_OVF_EN.
- Defined:
  - adds output port ovf (1 bit), reset 0.
  - in the final RUN cycle, ovf <= (carry into bit WIDTH-1) XOR (carry out of bit WIDTH-1), i.e. two's-complement signed overflow; for sub this uses the inverted B.
  - held alongside sum; cleared to 0 on accept.
- Not defined: port ovf absent; no extra logic.

Test Plan (WIDTH=16):
- 0x1234 + 0x4321, cin=0, sub=0 -> sum=0x5555, cout=0; done exactly 5 cycles after the accept edge, single-cycle pulse; ready low from accept through done.
- 0xFFFF + 0x0001, cin=0 -> sum=0x0000, cout=1 (carry ripples through all 4 nibbles); 0x0000 + 0x0000, cin=1 -> sum=0x0001, cout=0.
- sub=1, a=0x0005, b=0x0007, cin=1 -> sum=0xFFFE, cout=0; a=0x0007, b=0x0005 -> sum=0x0002, cout=1.
- Assert start again 2 cycles into RUN with different operands -> ignored; first result 0x5555 still produced; new start accepted in the IDLE cycle after done.
- clr in the 3rd RUN cycle -> IDLE next cycle, no done, ready=1.
- rst_n low mid-RUN -> all outputs return to reset values immediately.
- With ZJH_SEQ_OVF_EN:
  - 0x7FFF + 0x0001 -> sum=0x8000, ovf=1, cout=0.
  - 0x8000 - 0x0001 -> sum=0x7FFF, ovf=1.
  - 0x0001 + 0x0001 -> ovf=0.
